inv_sub_bytes_seq: RTL and testbench

- Sequences the inverse SubBytes step over a full 128-bit AES state for the decryption path.
- Shares LANES instances of the existing inverseSubBytes lookup across the 16 state bytes, spreading the work over 16/LANES cycles. This trades area for latency.
- Has a valid/ready handshake on input and output, so it slots between the InvShiftRows and AddRoundKey stages of the round controller.

---
 rtl/inv_sub_bytes_seq.sv | 159 +++++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Sequenced inverse SubBytes over a 128-bit AES state.
// LANES inverse S-box lookups are shared across the 16 state bytes.
// A full state therefore takes BEATS = 16/LANES lookup cycles.
// Valid/ready handshakes sit on both the input and the output.
module inv_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy,
    output logic [15:0]  blk_cnt
);

    localparam int BEATS = 16 / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Inverse AES S-box, indexed by the input byte value.
    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [127:0]     r_w;
    logic [127:0]     w_w_sub;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_blk_cnt;
    logic             w_load;
    logic             w_adv;
    logic             w_last;
    logic             w_hs;

    logic [3:0]       w_idx      [LANES];
    logic [7:0]       w_lane_in  [LANES];
    logic [7:0]       w_lane_out [LANES];

    assign w_last = (r_cnt == LAST_BEAT);

    // Lane j looks up byte cnt*LANES+j; byte i lives at bits [127-8i -: 8].
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign w_idx[j]      = 4'(32'(r_cnt) * LANES + j);
        assign w_lane_in[j]  = r_w[(15 - int'(w_idx[j])) * 8 +: 8];
        assign w_lane_out[j] = INV_SBOX[w_lane_in[j]];
    end

    // Merge the lane results into a copy of W; untouched bytes pass through.
    always_comb begin
        w_w_sub = r_w;
        for (int j = 0; j < LANES; j++) begin
            w_w_sub[(15 - int'(w_idx[j])) * 8 +: 8] = w_lane_out[j];
        end
    end

    // Next-state and step decode; flush overrides every other action.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        w_hs        = 1'b0;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        w_load      = 1'b1;
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    w_adv = 1'b1;
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        w_hs        = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Work register, beat counter and completed-block counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w       <= '0;
            r_cnt     <= '0;
            r_blk_cnt <= '0;
        end else begin
            if (flush) begin
                r_cnt <= '0;
            end else if (w_load) begin
                r_w   <= in_state;
                r_cnt <= '0;
            end else if (w_adv) begin
                r_w   <= w_w_sub;
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            end
            if (w_hs) begin
                r_blk_cnt <= r_blk_cnt + 16'd1;
            end
        end
    end

    assign in_ready  = (r_state == IDLE) && rst_n;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_state = r_w;
    assign blk_cnt   = r_blk_cnt;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Scoreboard bench for inv_sub_bytes_seq. The reference inverse S-box is
// derived from GF(2^8) arithmetic and the forward affine transform.
module tb_inv_sub_bytes_seq;

    localparam int BEATS = 4;

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, out_ready;
    logic [127:0] in_state;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_state;
    logic [15:0]  blk_cnt;

    logic         flush_x, in_valid_x, out_ready_x;
    logic [127:0] in_state_x;
    logic         in_ready_16, out_valid_16, busy_16;
    logic [127:0] out_state_16;
    logic [15:0]  blk_cnt_16;
    logic         in_ready_1, out_valid_1, busy_1;
    logic [127:0] out_state_1;
    logic [15:0]  blk_cnt_1;

    always #5 clk = ~clk;

    inv_sub_bytes_seq #(.LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .busy(busy), .blk_cnt(blk_cnt));

    inv_sub_bytes_seq #(.LANES(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush_x), .in_valid(in_valid_x), .in_ready(in_ready_16),
        .in_state(in_state_x), .out_valid(out_valid_16), .out_ready(out_ready_x),
        .out_state(out_state_16), .busy(busy_16), .blk_cnt(blk_cnt_16));

    inv_sub_bytes_seq #(.LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush_x), .in_valid(in_valid_x), .in_ready(in_ready_1),
        .in_state(in_state_x), .out_valid(out_valid_1), .out_ready(out_ready_x),
        .out_state(out_state_1), .busy(busy_1), .blk_cnt(blk_cnt_1));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] inv_tab [256];

    typedef struct {
        logic [127:0] st;
        int           vcyc;
    } exp_t;

    exp_t sb_q[$];
    int   acc_log[$];
    logic [15:0] exp_blk = 16'd0;
    logic prev_ov = 1'b0;

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // Forward S-box = affine(GF inverse); its inverse table is the reference.
    task automatic build_tab();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] st);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8*i -: 8] = inv_tab[st[127 - 8*i -: 8]];
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            exp_blk = 16'd0;
            prev_ov = 1'b0;
        end else begin
            chk16("blk_cnt", blk_cnt, exp_blk);
            chk1("in_ready_vs_busy", in_ready, !busy);
            if (out_valid) begin
                chk1("busy_in_done", busy, 1'b1);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h, expected none", out_state);
                end else begin
                    chk128("out_state", out_state, sb_q[0].st);
                    if (!prev_ov) chki("latency", cyc, sb_q[0].vcyc);
                end
            end
            if (flush && busy) begin
                if (sb_q.size() > 0) void'(sb_q.pop_front());
            end else if (out_valid && out_ready) begin
                if (sb_q.size() > 0) void'(sb_q.pop_front());
                exp_blk = exp_blk + 16'd1;
            end
            if (in_valid && in_ready && !flush) begin
                sb_q.push_back('{model(in_state), cyc + 1 + BEATS});
                acc_log.push_back(cyc + 1);
            end
            prev_ov = out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        chk1(name, busy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n0, lat16, lat1;
        logic [15:0] b;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_state = '0;
        flush_x = 1'b0; in_valid_x = 1'b0; out_ready_x = 1'b1; in_state_x = '0;
        build_tab();
        #2;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk16("rst_blk_cnt", blk_cnt, 16'd0);
        chk128("rst_out_state", out_state, 128'd0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk1("in_ready_after_reset", in_ready, 1'b1);
        tick();

        // All-zero state, latency 4
        in_state = '0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk1("t1_in_ready_drop", in_ready, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        chki("t1_latency", n, 4);
        chk128("t1_out", out_state, {16{8'h52}});
        wait_idle("t1_idle");

        // Known answer with backpressure
        b = blk_cnt;
        out_ready = 1'b0;
        in_state = 128'h00010203_04050607_08090A0B_0C0D0E0F; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        for (int i = 0; i < 6; i++) begin
            chk1("bp_out_valid", out_valid, 1'b1);
            chk1("bp_in_ready", in_ready, 1'b0);
            chk128("bp_out_state", out_state, 128'h52096AD5_3036A538_BF40A39E_81F3D7FB);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk1("bp_release_in_ready", in_ready, 1'b1);
        chk1("bp_release_out_valid", out_valid, 1'b0);
        chk16("bp_blk_cnt", blk_cnt, b + 16'd1);

        // Back-to-back
        n0 = acc_log.size();
        in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_valid = 1'b1;
        n = 0;
        while (acc_log.size() < n0 + 2 && n < 40) begin
            tick();
            n++;
            if (acc_log.size() == n0 + 1) in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        in_valid = 1'b0;
        if (acc_log.size() >= n0 + 2) chki("b2b_period", acc_log[n0 + 1] - acc_log[n0], BEATS + 2);
        else chki("b2b_accepts", acc_log.size() - n0, 2);
        wait_idle("b2b_idle");

        // Flush at cnt==2
        b = blk_cnt;
        in_state = {$urandom(), $urandom(), $urandom(), $urandom()}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk1("flush_busy", busy, 1'b0);
        chk1("flush_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            chk1("flush_no_out", out_valid, 1'b0);
            tick();
        end
        chk16("flush_blk_cnt", blk_cnt, b);

        // Asynchronous reset mid-RUN
        in_state = {$urandom(), $urandom(), $urandom(), $urandom()}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_in_ready", in_ready, 1'b0);
        chk1("arst_out_valid", out_valid, 1'b0);
        chk16("arst_blk_cnt", blk_cnt, 16'd0);
        chk128("arst_out_state", out_state, 128'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Randomised traffic with backpressure and occasional flush
        for (int k = 0; k < 40; k++) begin
            in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_valid = 1'b1;
            for (int w = 0; w < 40; w++) begin
                logic acc;
                out_ready = ($urandom_range(0, 3) != 0);
                flush     = ($urandom_range(0, 39) == 0);
                #0;
                acc = in_ready && !flush;
                tick();
                if (acc) break;
            end
            in_valid = 1'b0;
            flush    = 1'b0;
            n = $urandom_range(0, 3);
            for (int g = 0; g < n; g++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        out_ready = 1'b1;
        wait_idle("rand_idle");

        // LANES=16 and LANES=1 builds
        in_state_x = {16{8'h10}};
        chk1("x16_in_ready", in_ready_16, 1'b1);
        chk1("x1_in_ready", in_ready_1, 1'b1);
        in_valid_x = 1'b1;
        tick();
        in_valid_x = 1'b0;
        lat16 = -1;
        lat1  = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (out_valid_16 && lat16 < 0) begin
                lat16 = i;
                chk128("x16_out", out_state_16, {16{8'h7c}});
                chk128("x16_model", out_state_16, model(in_state_x));
            end
            if (out_valid_1 && lat1 < 0) begin
                lat1 = i;
                chk128("x1_out", out_state_1, {16{8'h7c}});
            end
        end
        chki("x16_latency", lat16, 1);
        chki("x1_latency", lat1, 16);
        chk16("x16_blk_cnt", blk_cnt_16, 16'd1);
        chk16("x1_blk_cnt", blk_cnt_1, 16'd1);
        chk1("x16_idle", busy_16, 1'b0);
        chk1("x1_idle", busy_1, 1'b0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
